pea_projectile_manager: RTL and testbench

- Consumer side of the per-row stop-X interface: owns up to NUM_PEAS live pea projectiles and advances each one right by PEA_SPEED pixels per frame.
- Retires a pea when it reaches the stop column of its row (zombie hit) or leaves the screen.
- Sits between plant firing logic (upstream fire requests), the stop-X calculator (stopX1..5 inputs) and the zombie damage logic and sprite renderer (downstream).

---
 rtl/pea_projectile_manager.sv | 177 +++++++++++++++++
 tb/tb_pea_projectile_manager.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pea_projectile_manager.sv
// pea_projectile_manager
// Owns up to NUM_PEAS live pea projectiles. Peas are spawned from fire
// requests while idle. On every frame tick the FSM walks all slots, one slot
// per cycle. Each live pea moves right by PEA_SPEED. A pea is retired when it
// reaches its row's stop column, which is a hit reported on hit_valid. A pea
// is also retired, without a hit, when it reaches the right edge of the screen.
//
// Handshake: fire_valid/fire_ready follow strict valid/ready rules. A request
// is consumed on any cycle where both are high. fire_ready never depends on
// fire_valid. A consumed request with fire_row > 4 is dropped without using a
// slot.

module pea_projectile_manager #(
    parameter int NUM_PEAS     = 8,
    parameter int PEA_SPEED    = 4,
    parameter int SCREEN_RIGHT = 640
) (
    input  logic                     MAX10_CLK1_50,
    input  logic                     Reset,
    input  logic                     frame_clk,
    input  logic                     fire_valid,
    input  logic [2:0]               fire_row,
    input  logic [9:0]               fire_x,
    output logic                     fire_ready,
    input  logic [9:0]               stopX1,
    input  logic [9:0]               stopX2,
    input  logic [9:0]               stopX3,
    input  logic [9:0]               stopX4,
    input  logic [9:0]               stopX5,
    output logic [NUM_PEAS-1:0]      pea_live,
    output logic [10*NUM_PEAS-1:0]   pea_x,
    output logic [3*NUM_PEAS-1:0]    pea_row,
    output logic                     hit_valid,
    output logic [2:0]               hit_row,
    output logic [9:0]               hit_x
);

    localparam int IDXW = (NUM_PEAS > 1) ? $clog2(NUM_PEAS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_PEAS - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [IDXW-1:0]     idx_q, idx_d;
    logic                frame_q;
    logic [NUM_PEAS-1:0] live_q, live_d;
    logic [9:0]          x_q   [NUM_PEAS];
    logic [9:0]          x_d   [NUM_PEAS];
    logic [2:0]          row_q [NUM_PEAS];
    logic [2:0]          row_d [NUM_PEAS];
    logic                hit_valid_q, hit_valid_d;
    logic [2:0]          hit_row_q, hit_row_d;
    logic [9:0]          hit_x_q, hit_x_d;

    logic                tick;
    logic                any_free;
    logic [IDXW-1:0]     free_idx;
    logic [10:0]         nx;
    logic [9:0]          stop_sel;

    assign tick     = frame_clk && !frame_q;
    assign any_free = ~&live_q;

    // Ready only in IDLE, and not on a tick cycle because the tick wins.
    // Held low while Reset is asserted so that every output reads 0 in reset.
    assign fire_ready = !Reset && (state_q == ST_IDLE) && !tick && any_free;

    // Find the lowest-index free slot. The loop runs downward, so the lowest
    // free index is the one left in free_idx at the end.
    always_comb begin
        free_idx = '0;
        for (int i = NUM_PEAS - 1; i >= 0; i--) begin
            if (!live_q[i]) free_idx = IDXW'(i);
        end
    end

    // Advance the pea in the slot being scanned. nx is one bit wider than x so
    // the sum cannot wrap. stop_sel picks the stop column for the pea's row.
    always_comb begin
        nx = {1'b0, x_q[idx_q]} + 11'(PEA_SPEED);
        case (row_q[idx_q])
            3'd0:    stop_sel = stopX1;
            3'd1:    stop_sel = stopX2;
            3'd2:    stop_sel = stopX3;
            3'd3:    stop_sel = stopX4;
            3'd4:    stop_sel = stopX5;
            default: stop_sel = 10'd0;
        endcase
    end

    // Next-state logic for the FSM, the slot table and the hit outputs.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        live_d      = live_q;
        x_d         = x_q;
        row_d       = row_q;
        hit_valid_d = 1'b0;
        hit_row_d   = hit_row_q;
        hit_x_d     = hit_x_q;
        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    state_d = ST_SCAN;
                    idx_d   = '0;
                end else if (fire_valid && fire_ready && (fire_row <= 3'd4)) begin
                    live_d[free_idx] = 1'b1;
                    x_d[free_idx]    = fire_x;
                    row_d[free_idx]  = fire_row;
                end
            end
            ST_SCAN: begin
                if (live_q[idx_q]) begin
                    if ((stop_sel != 10'd0) && (nx >= {1'b0, stop_sel})) begin
                        live_d[idx_q] = 1'b0;
                        hit_valid_d   = 1'b1;
                        hit_row_d     = row_q[idx_q];
                        hit_x_d       = stop_sel;
                    end else if (nx >= 11'(SCREEN_RIGHT)) begin
                        live_d[idx_q] = 1'b0;
                    end else begin
                        x_d[idx_q] = nx[9:0];
                    end
                end
                if (idx_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers. Reset clears everything at once, even in the middle of a scan.
    always_ff @(posedge MAX10_CLK1_50 or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            frame_q     <= 1'b0;
            live_q      <= '0;
            hit_valid_q <= 1'b0;
            hit_row_q   <= 3'd0;
            hit_x_q     <= 10'd0;
            for (int i = 0; i < NUM_PEAS; i++) begin
                x_q[i]   <= 10'd0;
                row_q[i] <= 3'd0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            frame_q     <= frame_clk;
            live_q      <= live_d;
            hit_valid_q <= hit_valid_d;
            hit_row_q   <= hit_row_d;
            hit_x_q     <= hit_x_d;
            for (int i = 0; i < NUM_PEAS; i++) begin
                x_q[i]   <= x_d[i];
                row_q[i] <= row_d[i];
            end
        end
    end

    // Pack the slot table onto the flat output buses.
    for (genvar g = 0; g < NUM_PEAS; g++) begin : g_pack
        assign pea_x[10*g +: 10] = x_q[g];
        assign pea_row[3*g +: 3] = row_q[g];
    end

    assign pea_live  = live_q;
    assign hit_valid = hit_valid_q;
    assign hit_row   = hit_row_q;
    assign hit_x     = hit_x_q;

endmodule

// File: tb/tb_pea_projectile_manager.sv
// Testbench for pea_projectile_manager using the default parameters (8 slots).
// Directed scenarios come first. Randomized frames follow, and each is checked
// against a slot-table model that applies the movement and retirement rules
// frame by frame.

module tb_pea_projectile_manager;

    localparam int N = 8;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic             frame_clk;
    logic             fire_valid;
    logic [2:0]       fire_row;
    logic [9:0]       fire_x;
    logic             fire_ready;
    logic [9:0]       stop [5];
    logic [N-1:0]     pea_live;
    logic [10*N-1:0]  pea_x;
    logic [3*N-1:0]   pea_row;
    logic             hit_valid;
    logic [2:0]       hit_row;
    logic [9:0]       hit_x;

    pea_projectile_manager dut (
        .MAX10_CLK1_50 (clk),
        .Reset         (rst),
        .frame_clk     (frame_clk),
        .fire_valid    (fire_valid),
        .fire_row      (fire_row),
        .fire_x        (fire_x),
        .fire_ready    (fire_ready),
        .stopX1        (stop[0]),
        .stopX2        (stop[1]),
        .stopX3        (stop[2]),
        .stopX4        (stop[3]),
        .stopX5        (stop[4]),
        .pea_live      (pea_live),
        .pea_x         (pea_x),
        .pea_row       (pea_row),
        .hit_valid     (hit_valid),
        .hit_row       (hit_row),
        .hit_x         (hit_x)
    );

    // ---------------- reference model / scoreboard ----------------
    int checks   = 0;
    int failures = 0;

    bit m_live [N];
    int m_x    [N];
    int m_row  [N];
    // Expected hits of the current frame: {slot, row, stop x}.
    logic [16:0] exp_q[$];

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_free_cnt();
        int c = 0;
        for (int i = 0; i < N; i++) if (!m_live[i]) c++;
        return c;
    endfunction

    function automatic logic [N-1:0] exp_live();
        logic [N-1:0] v = '0;
        for (int i = 0; i < N; i++) v[i] = m_live[i];
        return v;
    endfunction

    function automatic logic [10*N-1:0] exp_xvec();
        logic [10*N-1:0] v = '0;
        for (int i = 0; i < N; i++) if (m_live[i]) v[10*i +: 10] = 10'(m_x[i]);
        return v;
    endfunction

    function automatic logic [10*N-1:0] dut_xvec_live();
        logic [10*N-1:0] v = '0;
        for (int i = 0; i < N; i++) if (pea_live[i]) v[10*i +: 10] = pea_x[10*i +: 10];
        return v;
    endfunction

    function automatic logic [3*N-1:0] exp_rowvec();
        logic [3*N-1:0] v = '0;
        for (int i = 0; i < N; i++) if (m_live[i]) v[3*i +: 3] = 3'(m_row[i]);
        return v;
    endfunction

    function automatic logic [3*N-1:0] dut_rowvec_live();
        logic [3*N-1:0] v = '0;
        for (int i = 0; i < N; i++) if (pea_live[i]) v[3*i +: 3] = pea_row[3*i +: 3];
        return v;
    endfunction

    // One frame: every live pea moves right by 4. A pea is retired if it
    // reaches its row's nonzero stop column (a hit) or reaches column 640 (no hit).
    task automatic model_frame();
        int nx;
        int s;
        for (int k = 0; k < N; k++) begin
            if (m_live[k]) begin
                nx = m_x[k] + 4;
                s  = int'(stop[m_row[k]]);
                if (s != 0 && nx >= s) begin
                    m_live[k] = 0;
                    exp_q.push_back({4'(k), 3'(m_row[k]), 10'(s)});
                end else if (nx >= 640) begin
                    m_live[k] = 0;
                end else begin
                    m_x[k] = nx;
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_slots(input string tag);
        chk({tag, "_live"}, 80'(pea_live), 80'(exp_live()));
        chk({tag, "_x"}, 80'(dut_xvec_live()), 80'(exp_xvec()));
        chk({tag, "_row"}, 80'(dut_rowvec_live()), 80'(exp_rowvec()));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        for (int i = 0; i < N; i++) begin
            m_live[i] = 0;
            m_x[i]    = 0;
            m_row[i]  = 0;
        end
        exp_q.delete();
        chk("rst_live", 80'(pea_live), 80'(0));
        chk("rst_x", 80'(pea_x), 80'(0));
        chk("rst_row", 80'(pea_row), 80'(0));
        chk("rst_hit_valid", 80'(hit_valid), 80'(0));
        chk("rst_hit_row", 80'(hit_row), 80'(0));
        chk("rst_hit_x", 80'(hit_x), 80'(0));
        chk("rst_ready", 80'(fire_ready), 80'(0));
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic fire(input int row, input int x);
        bit acc;
        fire_valid = 1'b1;
        fire_row   = 3'(row);
        fire_x     = 10'(x);
        #1;
        acc = (m_free_cnt() > 0);
        chk("fire_ready", 80'(fire_ready), 80'(acc));
        if (acc && row <= 4) begin
            for (int i = 0; i < N; i++) begin
                if (!m_live[i]) begin
                    m_live[i] = 1;
                    m_x[i]    = x;
                    m_row[i]  = row;
                    break;
                end
            end
        end
        step();
        fire_valid = 1'b0;
    endtask

    // Raise frame_clk for one frame and check the scan: a hit on slot k shows
    // up on hit_valid k+1 cycles after the tick edge. With reraise set,
    // frame_clk rises again during the scan and must be ignored.
    task automatic do_tick(input bit reraise);
        bit exp_v;
        frame_clk = 1'b1;
        #1;
        chk("tick_ready", 80'(fire_ready), 80'(0));
        model_frame();
        step();
        frame_clk = 1'b0;
        chk("scan_ready_first", 80'(fire_ready), 80'(0));
        // A request offered during the scan must not be taken.
        fire_valid = 1'b1;
        fire_row   = 3'($urandom_range(0, 4));
        fire_x     = 10'($urandom_range(0, 639));
        for (int k = 0; k < N; k++) begin
            step();
            if (reraise && k == 3) frame_clk = 1'b1;
            exp_v = (exp_q.size() > 0) && (exp_q[0][16:13] == 4'(k));
            chk($sformatf("hit_valid_s%0d", k), 80'(hit_valid), 80'(exp_v));
            if (exp_v) begin
                chk($sformatf("hit_row_s%0d", k), 80'(hit_row), 80'(exp_q[0][12:10]));
                chk($sformatf("hit_x_s%0d", k), 80'(hit_x), 80'(exp_q[0][9:0]));
                void'(exp_q.pop_front());
            end
            if (k < N - 1) chk($sformatf("scan_ready_s%0d", k), 80'(fire_ready), 80'(0));
            if (k == N - 2) fire_valid = 1'b0;
        end
        check_slots("post_scan");
        chk("post_scan_ready", 80'(fire_ready), 80'(m_free_cnt() > 0));
        step();
        chk("post_scan_no_hit", 80'(hit_valid), 80'(0));
        if (reraise) begin
            step();
            chk("reraise_idle_ready", 80'(fire_ready), 80'(m_free_cnt() > 0));
            check_slots("reraise");
            frame_clk = 1'b0;
            step();
        end
        exp_q.delete();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        rst        = 1'b1;
        frame_clk  = 1'b0;
        fire_valid = 1'b0;
        fire_row   = 3'd0;
        fire_x     = 10'd0;
        for (int i = 0; i < 5; i++) stop[i] = 10'd0;
        do_reset();

        // Reset in the middle of a scan, with peas that would otherwise hit.
        stop[1] = 10'd200;
        fire(1, 196);
        fire(1, 196);
        fire(1, 196);
        frame_clk = 1'b1;
        step();
        frame_clk = 1'b0;
        step();
        step();
        do_reset();
        check_slots("after_mid_reset");
        do_tick(0);

        // Row 2 with no zombies: five frames take the pea from 100 to 120.
        do_reset();
        for (int i = 0; i < 5; i++) stop[i] = 10'd0;
        fire(2, 100);
        for (int t = 0; t < 5; t++) do_tick(0);
        chk("five_ticks_x", 80'(pea_x[9:0]), 80'(120));
        chk("five_ticks_live", 80'(pea_live[0]), 80'(1));

        // Row 0, stop 310: x goes 304, 308, then hits on the third frame.
        do_reset();
        stop[0] = 10'd310;
        fire(0, 300);
        for (int t = 0; t < 3; t++) do_tick(0);
        chk("hit_freed", 80'(pea_live[0]), 80'(0));

        // Three peas in row 1 at 196, stop 200: back-to-back hit pulses.
        do_reset();
        stop[0] = 10'd0;
        stop[1] = 10'd200;
        for (int i = 0; i < 3; i++) fire(1, 196);
        do_tick(0);

        // Screen edge: 636 + 4 = 640 retires the pea without a hit.
        do_reset();
        stop[1] = 10'd0;
        stop[4] = 10'd0;
        fire(4, 636);
        do_tick(0);

        // Spawned beyond the stop column: hits on the first scan.
        do_reset();
        stop[3] = 10'd450;
        fire(3, 500);
        do_tick(0);

        // Full table, free one slot, then an out-of-range row uses no slot.
        do_reset();
        stop[3] = 10'd0;
        for (int i = 0; i < N - 1; i++) fire(0, 10 * i);
        fire(1, 637);
        fire(2, 50);
        check_slots("full");
        do_tick(0);
        fire(5, 100);
        check_slots("row5_dropped");
        chk("row5_slot_still_free", 80'(fire_ready), 80'(1));
        do_tick(1);

        // Randomized frames.
        do_reset();
        for (int r = 0; r < 30; r++) begin
            int nf;
            nf = $urandom_range(0, 3);
            for (int f = 0; f < nf; f++) fire($urandom_range(0, 5), $urandom_range(0, 639));
            for (int i = 0; i < 5; i++)
                stop[i] = ($urandom_range(0, 2) == 0) ? 10'd0 : 10'($urandom_range(1, 639));
            do_tick($urandom_range(0, 4) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
